// File: rtl/window_fetch_unit_pkg.sv
// Shared widths, FSM state encoding and window layout helper for the window fetch unit.
package window_fetch_unit_pkg;

  localparam int unsigned DEF_ADDR_W = 19;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_DIM_W  = 10;
  localparam int unsigned WIN_N      = 5;  // window register is always 5x5, K=3 uses the top-left corner
  localparam int unsigned IDX_W      = 3;  // window-row index, 0..4

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_PRESENT = 2'd2,
    ST_FINISH  = 2'd3
  } state_t;

  // Bit offset of window element (i,j) in the row-major window bus.
  function automatic int unsigned win_off(input int unsigned i, input int unsigned j,
                                          input int unsigned dw);
    return (WIN_N * i + j) * dw;
  endfunction

endpackage

// File: rtl/window_addr_gen.sv
// Window position counters and incremental RAM address generation (no multiplier).
module window_addr_gen
  import window_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DIM_W  = DEF_DIM_W
) (
  input  logic              clk_c,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_base,
  input  logic              i_step,
  input  logic              i_adv,
  input  logic [DIM_W-1:0]  i_img_w,
  input  logic [DIM_W-1:0]  i_img_h,
  input  logic              i_filt5,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DIM_W-1:0]  o_row,
  output logic [DIM_W-1:0]  o_col,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_last_row,
  output logic              o_last_window
);

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_win_base;
  logic [DIM_W-1:0]  r_row;
  logic [DIM_W-1:0]  r_col;
  logic [IDX_W-1:0]  r_idx;

  logic [ADDR_W-1:0] w_next_base;
  logic [ADDR_W-1:0] w_stride;
  logic [DIM_W-1:0]  w_k;
  logic [DIM_W-1:0]  w_col_max;
  logic [DIM_W-1:0]  w_row_max;
  logic [IDX_W-1:0]  w_idx_max;
  logic              w_last_col;

  assign w_k        = i_filt5 ? DIM_W'(5) : DIM_W'(3);
  assign w_idx_max  = i_filt5 ? IDX_W'(4) : IDX_W'(2);
  assign w_col_max  = i_img_w - w_k;
  assign w_row_max  = i_img_h - w_k;
  assign w_last_col = (r_col == w_col_max);
  assign w_stride   = ADDR_W'(i_img_w);

  // Stepping right adds 1; leaving column W-K for the next window row adds K (= W - (W-K)).
  assign w_next_base = r_win_base + (w_last_col ? ADDR_W'(w_k) : ADDR_W'(1));

  assign o_addr        = r_addr;
  assign o_row         = r_row;
  assign o_col         = r_col;
  assign o_idx         = r_idx;
  assign o_last_row    = (r_idx == w_idx_max);
  assign o_last_window = (r_row == w_row_max) && w_last_col;

  // Counter and pointer update: load on start, add stride per fetched row, advance per window.
  always_ff @(posedge clk_c or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_win_base <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_idx      <= '0;
    end else if (i_load) begin
      r_addr     <= i_base;
      r_win_base <= i_base;
      r_row      <= '0;
      r_col      <= '0;
      r_idx      <= '0;
    end else if (i_step) begin
      r_addr <= r_addr + w_stride;
      r_idx  <= r_idx + IDX_W'(1);
    end else if (i_adv) begin
      r_addr     <= w_next_base;
      r_win_base <= w_next_base;
      r_idx      <= '0;
      if (w_last_col) begin
        r_col <= '0;
        r_row <= r_row + DIM_W'(1);
      end else begin
        r_col <= r_col + DIM_W'(1);
      end
    end
  end

endmodule

// File: rtl/window_fetch_unit.sv
// Fetches KxK windows row by row from a 5-byte-wide RAM and hands them out over valid/ready.
module window_fetch_unit
  import window_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DIM_W  = DEF_DIM_W
) (
  input  logic                          clk_c,
  input  logic                          rst_n,
  input  logic                          start_in,
  input  logic [ADDR_W-1:0]             base_addr_in,
  input  logic [DIM_W-1:0]              img_w_in,
  input  logic [DIM_W-1:0]              img_h_in,
  input  logic                          filt5_in,
  output logic                          ram_en_out,
  output logic                          ram_rw_out,
  output logic [ADDR_W-1:0]             ram_addr_out,
  input  logic [WIN_N*DATA_W-1:0]       ram_data_in,
  output logic                          win_valid_out,
  input  logic                          win_ready_in,
  output logic [WIN_N*WIN_N*DATA_W-1:0] win_data_out,
  output logic [DIM_W-1:0]              win_row_out,
  output logic [DIM_W-1:0]              win_col_out,
  output logic                          busy_out,
  output logic                          done_out
);

  localparam int unsigned ROW_W = WIN_N * DATA_W;
  localparam int unsigned WIN_W = WIN_N * WIN_N * DATA_W;
  localparam logic [ROW_W-1:0] MASK3 = {{(2*DATA_W){1'b0}}, {(3*DATA_W){1'b1}}};

  state_t            r_state;
  state_t            w_next;
  logic              r_filt5;
  logic [DIM_W-1:0]  r_img_w;
  logic [DIM_W-1:0]  r_img_h;
  logic              r_ram_en;
  logic              r_valid;
  logic              r_busy;
  logic              r_done;
  logic [WIN_W-1:0]  r_win;

  logic [DIM_W-1:0]  w_k_in;
  logic              w_degen;
  logic              w_load;
  logic              w_step;
  logic              w_adv;
  logic              w_last_row;
  logic              w_last_win;
  logic [IDX_W-1:0]  w_idx;
  logic [ROW_W-1:0]  w_row;

  assign w_k_in  = filt5_in ? DIM_W'(5) : DIM_W'(3);
  assign w_degen = (img_w_in < w_k_in) || (img_h_in < w_k_in);
  assign w_load  = (r_state == ST_IDLE) && start_in;
  assign w_step  = (r_state == ST_FETCH);
  assign w_adv   = (r_state == ST_PRESENT) && win_ready_in;
  assign w_row   = ram_data_in & (r_filt5 ? {ROW_W{1'b1}} : MASK3);

  window_addr_gen #(
    .ADDR_W (ADDR_W),
    .DIM_W  (DIM_W)
  ) u_addr_gen (
    .clk_c         (clk_c),
    .rst_n         (rst_n),
    .i_load        (w_load),
    .i_base        (base_addr_in),
    .i_step        (w_step),
    .i_adv         (w_adv),
    .i_img_w       (r_img_w),
    .i_img_h       (r_img_h),
    .i_filt5       (r_filt5),
    .o_addr        (ram_addr_out),
    .o_row         (win_row_out),
    .o_col         (win_col_out),
    .o_idx         (w_idx),
    .o_last_row    (w_last_row),
    .o_last_window (w_last_win)
  );

  // State register.
  always_ff @(posedge clk_c or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (start_in) w_next = w_degen ? ST_FINISH : ST_FETCH;
      ST_FETCH:   if (w_last_row) w_next = ST_PRESENT;
      ST_PRESENT: if (win_ready_in) w_next = w_last_win ? ST_FINISH : ST_FETCH;
      ST_FINISH:  w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Registered status outputs, decoded from the state being entered.
  always_ff @(posedge clk_c or negedge rst_n) begin
    if (!rst_n) begin
      r_ram_en <= 1'b0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_ram_en <= (w_next == ST_FETCH);
      r_valid  <= (w_next == ST_PRESENT);
      r_busy   <= (w_next == ST_FETCH) || (w_next == ST_PRESENT);
      r_done   <= (w_next == ST_FINISH);
    end
  end

  // Frame configuration, captured on an accepted start.
  always_ff @(posedge clk_c or negedge rst_n) begin
    if (!rst_n) begin
      r_filt5 <= 1'b0;
      r_img_w <= '0;
      r_img_h <= '0;
    end else if (w_load) begin
      r_filt5 <= filt5_in;
      r_img_w <= img_w_in;
      r_img_h <= img_h_in;
    end
  end

  // Window register: cleared per frame so K=3 leaves rows/cols 3-4 at zero.
  always_ff @(posedge clk_c or negedge rst_n) begin
    if (!rst_n) begin
      r_win <= '0;
    end else if (w_load) begin
      r_win <= '0;
    end else if (w_step) begin
      for (int unsigned i = 0; i < WIN_N; i++) begin
        if (w_idx == IDX_W'(i)) r_win[win_off(i, 0, DATA_W) +: ROW_W] <= w_row;
      end
    end
  end

  assign ram_en_out    = r_ram_en;
  assign ram_rw_out    = 1'b1;
  assign win_valid_out = r_valid;
  assign win_data_out  = r_win;
  assign busy_out      = r_busy;
  assign done_out      = r_done;

endmodule

// File: tb/tb_window_fetch_unit.sv
// Directed bench for window_fetch_unit with a RAM whose every byte equals its address low byte.
module tb_window_fetch_unit;
  import window_fetch_unit_pkg::*;

  localparam int unsigned AW    = 19;
  localparam int unsigned DW    = 8;
  localparam int unsigned MW    = 10;
  localparam int unsigned WIN_W = 25 * DW;

  logic              clk_c        = 1'b0;
  logic              rst_n        = 1'b0;
  logic              start_in     = 1'b0;
  logic [AW-1:0]     base_addr_in = '0;
  logic [MW-1:0]     img_w_in     = '0;
  logic [MW-1:0]     img_h_in     = '0;
  logic              filt5_in     = 1'b0;
  logic              win_ready_in = 1'b0;
  logic              ram_en_out;
  logic              ram_rw_out;
  logic [AW-1:0]     ram_addr_out;
  logic [5*DW-1:0]   ram_data_in;
  logic              win_valid_out;
  logic [WIN_W-1:0]  win_data_out;
  logic [MW-1:0]     win_row_out;
  logic [MW-1:0]     win_col_out;
  logic              busy_out;
  logic              done_out;

  int n_checks = 0;
  int n_fail   = 0;

  window_fetch_unit dut (
    .clk_c         (clk_c),
    .rst_n         (rst_n),
    .start_in      (start_in),
    .base_addr_in  (base_addr_in),
    .img_w_in      (img_w_in),
    .img_h_in      (img_h_in),
    .filt5_in      (filt5_in),
    .ram_en_out    (ram_en_out),
    .ram_rw_out    (ram_rw_out),
    .ram_addr_out  (ram_addr_out),
    .ram_data_in   (ram_data_in),
    .win_valid_out (win_valid_out),
    .win_ready_in  (win_ready_in),
    .win_data_out  (win_data_out),
    .win_row_out   (win_row_out),
    .win_col_out   (win_col_out),
    .busy_out      (busy_out),
    .done_out      (done_out)
  );

  always #5 clk_c = ~clk_c;

  // Combinational RAM: bytes addr+4..addr+0, each holding its address low byte.
  function automatic logic [5*DW-1:0] ram_word(input logic [AW-1:0] a);
    logic [5*DW-1:0] v;
    logic [AW-1:0]   t;
    v = '0;
    for (int unsigned k = 0; k < 5; k++) begin
      t = a + AW'(k);
      v[k*DW +: DW] = t[DW-1:0];
    end
    return v;
  endfunction

  assign ram_data_in = ram_word(ram_addr_out);

  // Reference window at (r,c) for base b, width w, size k.
  function automatic logic [WIN_W-1:0] exp_win(input logic [AW-1:0] b, input int unsigned w,
                                               input int unsigned k, input int unsigned r,
                                               input int unsigned c);
    logic [WIN_W-1:0] v;
    logic [AW-1:0]    a;
    v = '0;
    for (int unsigned i = 0; i < k; i++) begin
      for (int unsigned j = 0; j < k; j++) begin
        a = b + AW'((r + i) * w + c + j);
        v[win_off(i, j, DW) +: DW] = a[DW-1:0];
      end
    end
    return v;
  endfunction

  task automatic start_frame(input logic [AW-1:0] b, input logic [MW-1:0] w,
                             input logic [MW-1:0] h, input logic k5);
    @(negedge clk_c);
    base_addr_in = b;
    img_w_in     = w;
    img_h_in     = h;
    filt5_in     = k5;
    start_in     = 1'b1;
    @(negedge clk_c);
    start_in     = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < budget; t++) begin
      if (win_valid_out === 1'b1) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk_c);
    end
    ok = (win_valid_out === 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk_c);
    n_checks++;
    if ({ram_en_out, ram_rw_out, win_valid_out, busy_out, done_out} !== 5'b01000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got en/rw/valid/busy/done=%b want 01000",
               {ram_en_out, ram_rw_out, win_valid_out, busy_out, done_out});
    end
    n_checks++;
    if (ram_addr_out !== '0 || win_data_out !== '0 || win_row_out !== '0 || win_col_out !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got addr=%h row=%0d col=%0d data=%h want all zero",
               ram_addr_out, win_row_out, win_col_out, win_data_out);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk_c);
    n_checks++;
    if (busy_out !== 1'b0 || ram_en_out !== 1'b0 || done_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b en=%b done=%b want 0 0 0", busy_out, ram_en_out, done_out);
    end
  endtask

  task automatic test_k3_raster();
    logic [WIN_W-1:0] exp0;
    int unsigned      n;
    int               last_v;
    bit               done_seen;
    exp0 = '0;
    exp0[23:0]  = 24'h020100;
    exp0[63:40] = 24'h070605;
    exp0[103:80] = 24'h0C0B0A;
    win_ready_in = 1'b1;
    start_frame(19'h00100, 10'd5, 10'd5, 1'b0);
    n_checks++;
    if (ram_en_out !== 1'b1 || ram_addr_out !== 19'h00100 || busy_out !== 1'b1) begin
      n_fail++;
      $display("FAIL k3_fetch0: got en=%b addr=%h busy=%b want 1 00100 1", ram_en_out, ram_addr_out, busy_out);
    end
    @(negedge clk_c);
    n_checks++;
    if (ram_en_out !== 1'b1 || ram_addr_out !== 19'h00105) begin
      n_fail++;
      $display("FAIL k3_fetch1: got en=%b addr=%h want 1 00105", ram_en_out, ram_addr_out);
    end
    @(negedge clk_c);
    n_checks++;
    if (ram_addr_out !== 19'h0010A || win_valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL k3_fetch2: got addr=%h valid=%b want 0010A 0", ram_addr_out, win_valid_out);
    end
    @(negedge clk_c);
    n_checks++;
    if (win_valid_out !== 1'b1 || ram_en_out !== 1'b0) begin
      n_fail++;
      $display("FAIL k3_latency: got valid=%b en=%b want 1 0", win_valid_out, ram_en_out);
    end
    n_checks++;
    if (win_data_out !== exp0) begin
      n_fail++;
      $display("FAIL k3_first_window: got %h want %h", win_data_out, exp0);
    end
    n = 0;
    last_v = -10;
    done_seen = 1'b0;
    for (int cyc = 0; cyc < 80 && !done_seen; cyc++) begin
      if (win_valid_out === 1'b1) begin
        n_checks++;
        if (n >= 9 || win_row_out !== MW'(n / 3) || win_col_out !== MW'(n % 3) ||
            win_data_out !== exp_win(19'h00100, 5, 3, n / 3, n % 3)) begin
          n_fail++;
          $display("FAIL k3_window%0d: got row=%0d col=%0d data=%h want row=%0d col=%0d data=%h",
                   n, win_row_out, win_col_out, win_data_out, n / 3, n % 3,
                   exp_win(19'h00100, 5, 3, n / 3, n % 3));
        end
        n++;
        last_v = cyc;
      end
      if (done_out === 1'b1) begin
        done_seen = 1'b1;
        n_checks++;
        if (cyc != last_v + 1 || busy_out !== 1'b0) begin
          n_fail++;
          $display("FAIL k3_done_timing: got done at cycle %0d busy=%b want cycle %0d busy=0",
                   cyc, busy_out, last_v + 1);
        end
      end
      @(negedge clk_c);
    end
    n_checks++;
    if (n != 9 || !done_seen) begin
      n_fail++;
      $display("FAIL k3_count: got %0d windows done=%b want 9 windows done=1", n, done_seen);
    end
    n_checks++;
    if (done_out !== 1'b0) begin
      n_fail++;
      $display("FAIL k3_done_pulse: got done=%b one cycle later want 0", done_out);
    end
  endtask

  task automatic test_k5_single();
    win_ready_in = 1'b1;
    start_frame(19'h00000, 10'd5, 10'd5, 1'b1);
    for (int unsigned k = 0; k < 5; k++) begin
      n_checks++;
      if (win_valid_out !== 1'b0 || ram_en_out !== 1'b1 || ram_addr_out !== AW'(5 * k)) begin
        n_fail++;
        $display("FAIL k5_fetch%0d: got valid=%b en=%b addr=%h want 0 1 %h",
                 k, win_valid_out, ram_en_out, ram_addr_out, AW'(5 * k));
      end
      @(negedge clk_c);
    end
    n_checks++;
    if (win_valid_out !== 1'b1) begin
      n_fail++;
      $display("FAIL k5_latency: got valid=%b want 1", win_valid_out);
    end
    n_checks++;
    if (win_data_out[192 +: 8] !== 8'h18 || win_data_out !== exp_win(19'h00000, 5, 5, 0, 0)) begin
      n_fail++;
      $display("FAIL k5_data: got e44=%h data=%h want e44=18 data=%h",
               win_data_out[192 +: 8], win_data_out, exp_win(19'h00000, 5, 5, 0, 0));
    end
    @(negedge clk_c);
    n_checks++;
    if (done_out !== 1'b1 || win_valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL k5_done: got done=%b valid=%b want 1 0", done_out, win_valid_out);
    end
    @(negedge clk_c);
    n_checks++;
    if (done_out !== 1'b0 || win_valid_out !== 1'b0 || busy_out !== 1'b0) begin
      n_fail++;
      $display("FAIL k5_single: got done=%b valid=%b busy=%b want 0 0 0", done_out, win_valid_out, busy_out);
    end
  endtask

  task automatic test_backpressure();
    logic [WIN_W-1:0] held;
    int unsigned      n;
    bit               ok;
    bit               done_seen;
    win_ready_in = 1'b1;
    start_frame(19'h00100, 10'd5, 10'd5, 1'b0);
    wait_valid(10, ok);
    n_checks++;
    if (!ok || win_col_out !== '0) begin
      n_fail++;
      $display("FAIL bp_first: got valid=%b col=%0d want 1 0", ok, win_col_out);
    end
    @(negedge clk_c);
    win_ready_in = 1'b0;
    wait_valid(10, ok);
    n_checks++;
    if (!ok || win_row_out !== '0 || win_col_out !== MW'(1) ||
        win_data_out !== exp_win(19'h00100, 5, 3, 0, 1)) begin
      n_fail++;
      $display("FAIL bp_second: got valid=%b row=%0d col=%0d data=%h want 1 0 1 %h",
               ok, win_row_out, win_col_out, win_data_out, exp_win(19'h00100, 5, 3, 0, 1));
    end
    held = win_data_out;
    for (int t = 0; t < 7; t++) begin
      n_checks++;
      if (win_valid_out !== 1'b1 || win_data_out !== held || win_row_out !== '0 ||
          win_col_out !== MW'(1) || ram_en_out !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got valid=%b row=%0d col=%0d en=%b data=%h want 1 0 1 0 %h",
                 t, win_valid_out, win_row_out, win_col_out, ram_en_out, win_data_out, held);
      end
      start_in = (t == 2);
      if (t == 2) base_addr_in = 19'h05555;
      @(negedge clk_c);
    end
    start_in = 1'b0;
    win_ready_in = 1'b1;
    n = 1;
    done_seen = 1'b0;
    for (int cyc = 0; cyc < 60 && !done_seen; cyc++) begin
      if (win_valid_out === 1'b1) begin
        n_checks++;
        if (n >= 9 || win_row_out !== MW'(n / 3) || win_col_out !== MW'(n % 3) ||
            win_data_out !== exp_win(19'h00100, 5, 3, n / 3, n % 3)) begin
          n_fail++;
          $display("FAIL bp_window%0d: got row=%0d col=%0d data=%h want row=%0d col=%0d",
                   n, win_row_out, win_col_out, win_data_out, n / 3, n % 3);
        end
        n++;
      end
      if (done_out === 1'b1) done_seen = 1'b1;
      @(negedge clk_c);
    end
    n_checks++;
    if (n != 9 || !done_seen) begin
      n_fail++;
      $display("FAIL bp_count: got %0d windows done=%b want 9 done=1", n, done_seen);
    end
  endtask

  task automatic test_degenerate();
    bit en_seen;
    bit valid_seen;
    bit busy_seen;
    int done_cnt;
    int first_done;
    en_seen = 1'b0;
    valid_seen = 1'b0;
    busy_seen = 1'b0;
    done_cnt = 0;
    first_done = -1;
    win_ready_in = 1'b1;
    start_frame(19'h00200, 10'd2, 10'd9, 1'b0);
    for (int cyc = 1; cyc <= 6; cyc++) begin
      if (ram_en_out === 1'b1) en_seen = 1'b1;
      if (win_valid_out === 1'b1) valid_seen = 1'b1;
      if (busy_out === 1'b1) busy_seen = 1'b1;
      if (done_out === 1'b1) begin
        done_cnt++;
        if (first_done < 0) first_done = cyc;
      end
      @(negedge clk_c);
    end
    n_checks++;
    if (en_seen || valid_seen || busy_seen) begin
      n_fail++;
      $display("FAIL degen_quiet: got en=%b valid=%b busy=%b seen want none", en_seen, valid_seen, busy_seen);
    end
    n_checks++;
    if (done_cnt != 1 || first_done < 1 || first_done > 2) begin
      n_fail++;
      $display("FAIL degen_done: got %0d pulses first at cycle %0d want 1 pulse within 2 cycles",
               done_cnt, first_done);
    end
  endtask

  task automatic test_wrap();
    int unsigned n;
    bit          done_seen;
    win_ready_in = 1'b1;
    start_frame(19'h7FFFE, 10'd4, 10'd3, 1'b0);
    n_checks++;
    if (ram_addr_out !== 19'h7FFFE) begin
      n_fail++;
      $display("FAIL wrap_row0: got addr=%h want 7fffe", ram_addr_out);
    end
    @(negedge clk_c);
    n_checks++;
    if (ram_addr_out !== 19'h00002) begin
      n_fail++;
      $display("FAIL wrap_row1: got addr=%h want 00002", ram_addr_out);
    end
    @(negedge clk_c);
    n_checks++;
    if (ram_addr_out !== 19'h00006) begin
      n_fail++;
      $display("FAIL wrap_row2: got addr=%h want 00006", ram_addr_out);
    end
    @(negedge clk_c);
    n_checks++;
    if (win_valid_out !== 1'b1 || win_data_out[23:0] !== 24'h00FFFE || win_data_out[63:40] !== 24'h040302 ||
        win_data_out !== exp_win(19'h7FFFE, 4, 3, 0, 0)) begin
      n_fail++;
      $display("FAIL wrap_data: got valid=%b data=%h want 1 %h",
               win_valid_out, win_data_out, exp_win(19'h7FFFE, 4, 3, 0, 0));
    end
    n = 0;
    done_seen = 1'b0;
    for (int cyc = 0; cyc < 30 && !done_seen; cyc++) begin
      if (win_valid_out === 1'b1) n++;
      if (done_out === 1'b1) done_seen = 1'b1;
      @(negedge clk_c);
    end
    n_checks++;
    if (n != 2 || !done_seen) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d windows done=%b want 2 done=1", n, done_seen);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit bad;
    bit done_seen;
    win_ready_in = 1'b1;
    start_frame(19'h00100, 10'd5, 10'd5, 1'b0);
    @(negedge clk_c);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ram_en_out !== 1'b0 || ram_addr_out !== '0 || busy_out !== 1'b0 || win_valid_out !== 1'b0 ||
        done_out !== 1'b0 || ram_rw_out !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_fetch: got en=%b addr=%h busy=%b valid=%b done=%b rw=%b want 0 0 0 0 0 1",
               ram_en_out, ram_addr_out, busy_out, win_valid_out, done_out, ram_rw_out);
    end
    done_seen = 1'b0;
    bad = 1'b0;
    repeat (2) begin
      @(negedge clk_c);
      if (done_out !== 1'b0) done_seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk_c);
      if (done_out !== 1'b0) done_seen = 1'b1;
      if (busy_out !== 1'b0 || ram_en_out !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (done_seen || bad) begin
      n_fail++;
      $display("FAIL rstmid_quiet: got done_seen=%b activity=%b want 0 0", done_seen, bad);
    end
    win_ready_in = 1'b0;
    start_frame(19'h00000, 10'd5, 10'd5, 1'b0);
    wait_valid(10, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rstmid_present: got valid=%b want 1", win_valid_out);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (win_valid_out !== 1'b0 || win_data_out !== '0) begin
      n_fail++;
      $display("FAIL rstmid_async: got valid=%b data=%h want 0 0", win_valid_out, win_data_out);
    end
    @(negedge clk_c);
    rst_n = 1'b1;
    win_ready_in = 1'b1;
    start_frame(19'h00040, 10'd5, 10'd5, 1'b0);
    wait_valid(10, ok);
    n_checks++;
    if (!ok || win_row_out !== '0 || win_col_out !== '0 || win_data_out !== exp_win(19'h00040, 5, 3, 0, 0)) begin
      n_fail++;
      $display("FAIL rstmid_restart: got valid=%b row=%0d col=%0d data=%h want 1 0 0 %h",
               ok, win_row_out, win_col_out, win_data_out, exp_win(19'h00040, 5, 3, 0, 0));
    end
    done_seen = 1'b0;
    for (int cyc = 0; cyc < 60 && !done_seen; cyc++) begin
      if (done_out === 1'b1) done_seen = 1'b1;
      @(negedge clk_c);
    end
    n_checks++;
    if (!done_seen) begin
      n_fail++;
      $display("FAIL rstmid_finish: got done_seen=0 want 1");
    end
  endtask

  initial begin
    test_reset();
    test_k3_raster();
    test_k5_single();
    test_backpressure();
    test_degenerate();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
